// File: rtl/alu_group_sequencer.sv
// alu_group_sequencer: clocked sequencer for the 8-bit ALU instruction class
// (register, (HL), immediate and (IX+d)/(IY+d) operand forms). It drives the
// address-select, read-phase, operand/op-select, result and flag strobes,
// plus a busy/error handshake.
//
// state | meaning
// IDLE  | waiting for Start; Busy low, XPT held at 0
// DISP  | reading the index displacement byte at PC
// MEM   | reading the operand byte at HL, IX, IY or PC
// EXEC  | one-cycle ALU strobe cycle
// DONE  | one-cycle P2_Set_CM1 pulse, then back to IDLE
module alu_group_sequencer #(
  parameter int XPT_WIDTH    = 5,
  parameter int ENABLE_IMM   = 1,
  parameter int ENABLE_INDEX = 1,
  parameter int WAIT_LIMIT   = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Start,
  input  logic [7:0]           Opcode,
  input  logic [1:0]           Prefix,
  input  logic                 Abort,
  input  logic                 MemReady,
  input  logic [7:0]           MemData,
  output logic                 Busy,
  output logic                 Error,
  output logic [XPT_WIDTH-1:0] XPT,
  output logic [7:0]           Disp,
  output logic                 PI_SelectAd_PC,
  output logic                 PI_SelectAd_HL,
  output logic                 PI_SelectAd_IX,
  output logic                 PI_SelectAd_IY,
  output logic                 PC_RA0,
  output logic                 PC_RA1,
  output logic                 PC_RA2,
  output logic                 PA_Select_B_low,
  output logic                 PA_Select_C_low,
  output logic                 PA_Select_D_low,
  output logic                 PA_Select_E_low,
  output logic                 PA_Select_H_low,
  output logic                 PA_Select_L_low,
  output logic                 PA_Select_A_low,
  output logic                 PA_Select_Mem_low,
  output logic                 PA_Select_A_high,
  output logic                 PA_ADD,
  output logic                 PA_ADC,
  output logic                 PA_SUB,
  output logic                 PA_SBC,
  output logic                 PA_AND,
  output logic                 PA_XOR,
  output logic                 PA_OR,
  output logic                 PA_CP,
  output logic                 PR_InvertIn,
  output logic                 PR_Write_A,
  output logic                 PF_Write_S,
  output logic                 PF_Write_Z,
  output logic                 PF_Write_H,
  output logic                 PF_Write_PV,
  output logic                 PF_Write_N,
  output logic                 PF_Write_C,
  output logic                 P2_Set_CM1
);

  localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [XPT_WIDTH-1:0] XPT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DISP = 3'd1,
    S_MEM  = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           opc_q, opc_d;
  logic [1:0]           pfx_q, pfx_d;
  logic [7:0]           disp_q, disp_d;
  logic [XPT_WIDTH-1:0] xpt_q, xpt_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic                 first_q, first_d;
  logic                 err_q, err_d;

  logic       in_read, ra_wait, ra_cap, timeout, legal, rd_enter;
  logic [1:0] pfx_eff;

  // Read-phase qualifiers: first cycle of a read is RA0, later cycles follow MemReady.
  assign in_read = (state_q == S_DISP) || (state_q == S_MEM);
  assign ra_wait = in_read && !first_q && !MemReady;
  assign ra_cap  = in_read && !first_q && MemReady;
  // The wait down-counter is loaded with WAIT_LIMIT; its last RA1 cycle is terminal.
  assign timeout = (WAIT_LIMIT != 0) && ra_wait && (wcnt_q == WW'(1));
  assign pfx_eff = (ENABLE_INDEX != 0) ? Prefix : 2'b00;
  assign legal   = (Opcode[7:6] == 2'b10) ||
                   ((ENABLE_IMM != 0) && (Opcode[7:6] == 2'b11) && (Opcode[2:0] == 3'b110));

  // Next-state, latches, wait counter and step counter.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    pfx_d   = pfx_q;
    disp_d  = disp_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (legal) begin
            opc_d = Opcode;
            pfx_d = pfx_eff;
            if (Opcode[2:0] != 3'b110)                    state_d = S_EXEC;
            else if (Opcode[7:6] == 2'b11)                state_d = S_MEM;
            else if (pfx_eff == 2'b01 || pfx_eff == 2'b10) state_d = S_DISP;
            else                                          state_d = S_MEM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DISP: begin
        if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (ra_cap) begin
          disp_d  = MemData;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (ra_cap) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over capture and timeout: no Error, no displacement update.
    if (Abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
      disp_d  = disp_q;
    end

    rd_enter = (state_d != state_q) && ((state_d == S_DISP) || (state_d == S_MEM));
    first_d  = rd_enter;
    if (rd_enter)
      wcnt_d = WW'(WAIT_LIMIT);
    else if (ra_wait && (wcnt_q != '0))
      wcnt_d = wcnt_q - 1'b1;
    else
      wcnt_d = wcnt_q;

    if (state_d == S_IDLE)
      xpt_d = '0;
    else if (xpt_q != XPT_MAX)
      xpt_d = xpt_q + 1'b1;
    else
      xpt_d = xpt_q;
  end

  // State and latch registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      pfx_q   <= '0;
      disp_q  <= '0;
      xpt_q   <= '0;
      wcnt_q  <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      pfx_q   <= pfx_d;
      disp_q  <= disp_d;
      xpt_q   <= xpt_d;
      wcnt_q  <= wcnt_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign Busy  = (state_q != S_IDLE);
  assign Error = err_q;
  assign XPT   = xpt_q;
  assign Disp  = disp_q;

  // Strobe decode from registered state and the latched opcode/prefix.
  always_comb begin
    PI_SelectAd_PC    = 1'b0;
    PI_SelectAd_HL    = 1'b0;
    PI_SelectAd_IX    = 1'b0;
    PI_SelectAd_IY    = 1'b0;
    PA_Select_B_low   = 1'b0;
    PA_Select_C_low   = 1'b0;
    PA_Select_D_low   = 1'b0;
    PA_Select_E_low   = 1'b0;
    PA_Select_H_low   = 1'b0;
    PA_Select_L_low   = 1'b0;
    PA_Select_A_low   = 1'b0;
    PA_Select_Mem_low = 1'b0;
    PA_Select_A_high  = 1'b0;
    PA_ADD            = 1'b0;
    PA_ADC            = 1'b0;
    PA_SUB            = 1'b0;
    PA_SBC            = 1'b0;
    PA_AND            = 1'b0;
    PA_XOR            = 1'b0;
    PA_OR             = 1'b0;
    PA_CP             = 1'b0;
    PR_InvertIn       = 1'b0;
    PR_Write_A        = 1'b0;
    PF_Write_S        = 1'b0;
    PF_Write_Z        = 1'b0;
    PF_Write_H        = 1'b0;
    PF_Write_PV       = 1'b0;
    PF_Write_N        = 1'b0;
    PF_Write_C        = 1'b0;
    P2_Set_CM1        = 1'b0;
    PC_RA0            = in_read && first_q;
    PC_RA1            = ra_wait;
    PC_RA2            = ra_cap;
    unique case (state_q)
      S_DISP: PI_SelectAd_PC = 1'b1;
      S_MEM: begin
        if (opc_q[7:6] == 2'b11)  PI_SelectAd_PC = 1'b1;
        else if (pfx_q == 2'b01)  PI_SelectAd_IX = 1'b1;
        else if (pfx_q == 2'b10)  PI_SelectAd_IY = 1'b1;
        else                      PI_SelectAd_HL = 1'b1;
      end
      S_EXEC: begin
        PA_Select_A_high = 1'b1;
        PF_Write_S       = 1'b1;
        PF_Write_Z       = 1'b1;
        PF_Write_H       = 1'b1;
        PF_Write_PV      = 1'b1;
        PF_Write_N       = 1'b1;
        PF_Write_C       = 1'b1;
        case (opc_q[2:0])
          3'd0: PA_Select_B_low   = 1'b1;
          3'd1: PA_Select_C_low   = 1'b1;
          3'd2: PA_Select_D_low   = 1'b1;
          3'd3: PA_Select_E_low   = 1'b1;
          3'd4: PA_Select_H_low   = 1'b1;
          3'd5: PA_Select_L_low   = 1'b1;
          3'd6: PA_Select_Mem_low = 1'b1;
          3'd7: PA_Select_A_low   = 1'b1;
        endcase
        case (opc_q[5:3])
          3'd0: PA_ADD = 1'b1;
          3'd1: PA_ADC = 1'b1;
          3'd2: PA_SUB = 1'b1;
          3'd3: PA_SBC = 1'b1;
          3'd4: PA_AND = 1'b1;
          3'd5: PA_XOR = 1'b1;
          3'd6: PA_OR  = 1'b1;
          3'd7: PA_CP  = 1'b1;
        endcase
        PR_InvertIn = (opc_q[5:3] == 3'd2) || (opc_q[5:3] == 3'd3) || (opc_q[5:3] == 3'd7);
        PR_Write_A  = (opc_q[5:3] != 3'd7);
      end
      S_DONE:  P2_Set_CM1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_group_sequencer.sv
`timescale 1ns/1ps
// Bench for alu_group_sequencer: each instruction is expanded into a list of
// expected phases (read cycles, EXEC, DONE) from the operand form, wait counts
// and abort point, and every cycle's strobes are compared against that list.
module tb_alu_group_sequencer;

  localparam int XW   = 3;
  localparam int XMAX = (1 << XW) - 1;
  localparam int WLIM = 3;

  localparam logic [2:0] PH_RA0 = 3'd0, PH_RA1 = 3'd1, PH_RA2 = 3'd2,
                         PH_EXEC = 3'd3, PH_DONE = 3'd4, PH_IDLE = 3'd5;
  localparam logic [1:0] AD_PC = 2'd0, AD_HL = 2'd1, AD_IX = 2'd2, AD_IY = 2'd3;

  logic       CLK = 1'b0;
  logic       RESET, Start, Abort, MemReady;
  logic [7:0] Opcode, MemData;
  logic [1:0] Prefix;

  // Strobe vectors: 34 Busy, 33 Error, 32..29 PI PC/HL/IX/IY, 28..26 RA0/1/2,
  // 25..18 low select A,Mem,L,H,E,D,C,B, 17 A_high, 16..9 CP..ADD,
  // 8 InvertIn, 7 Write_A, 6..1 flags S,Z,H,PV,N,C, 0 Set_CM1.
  wire [34:0]   obs, obs2;
  wire [XW-1:0] xpt;
  wire [4:0]    xpt2;
  wire [7:0]    disp, disp2;

  always #5 CLK = ~CLK;

  alu_group_sequencer #(.XPT_WIDTH(XW), .ENABLE_IMM(1), .ENABLE_INDEX(1), .WAIT_LIMIT(WLIM)) u_dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Opcode(Opcode), .Prefix(Prefix), .Abort(Abort),
    .MemReady(MemReady), .MemData(MemData),
    .Busy(obs[34]), .Error(obs[33]), .XPT(xpt), .Disp(disp),
    .PI_SelectAd_PC(obs[32]), .PI_SelectAd_HL(obs[31]), .PI_SelectAd_IX(obs[30]), .PI_SelectAd_IY(obs[29]),
    .PC_RA0(obs[28]), .PC_RA1(obs[27]), .PC_RA2(obs[26]),
    .PA_Select_A_low(obs[25]), .PA_Select_Mem_low(obs[24]), .PA_Select_L_low(obs[23]), .PA_Select_H_low(obs[22]),
    .PA_Select_E_low(obs[21]), .PA_Select_D_low(obs[20]), .PA_Select_C_low(obs[19]), .PA_Select_B_low(obs[18]),
    .PA_Select_A_high(obs[17]),
    .PA_CP(obs[16]), .PA_OR(obs[15]), .PA_XOR(obs[14]), .PA_AND(obs[13]),
    .PA_SBC(obs[12]), .PA_SUB(obs[11]), .PA_ADC(obs[10]), .PA_ADD(obs[9]),
    .PR_InvertIn(obs[8]), .PR_Write_A(obs[7]),
    .PF_Write_S(obs[6]), .PF_Write_Z(obs[5]), .PF_Write_H(obs[4]), .PF_Write_PV(obs[3]),
    .PF_Write_N(obs[2]), .PF_Write_C(obs[1]), .P2_Set_CM1(obs[0])
  );

  // Second instance without immediate or index support; Abort held high so it
  // never stays busy for more than one cycle after accepting a Start.
  alu_group_sequencer #(.ENABLE_IMM(0), .ENABLE_INDEX(0)) u_dut_noimm (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Opcode(Opcode), .Prefix(Prefix), .Abort(1'b1),
    .MemReady(MemReady), .MemData(MemData),
    .Busy(obs2[34]), .Error(obs2[33]), .XPT(xpt2), .Disp(disp2),
    .PI_SelectAd_PC(obs2[32]), .PI_SelectAd_HL(obs2[31]), .PI_SelectAd_IX(obs2[30]), .PI_SelectAd_IY(obs2[29]),
    .PC_RA0(obs2[28]), .PC_RA1(obs2[27]), .PC_RA2(obs2[26]),
    .PA_Select_A_low(obs2[25]), .PA_Select_Mem_low(obs2[24]), .PA_Select_L_low(obs2[23]), .PA_Select_H_low(obs2[22]),
    .PA_Select_E_low(obs2[21]), .PA_Select_D_low(obs2[20]), .PA_Select_C_low(obs2[19]), .PA_Select_B_low(obs2[18]),
    .PA_Select_A_high(obs2[17]),
    .PA_CP(obs2[16]), .PA_OR(obs2[15]), .PA_XOR(obs2[14]), .PA_AND(obs2[13]),
    .PA_SBC(obs2[12]), .PA_SUB(obs2[11]), .PA_ADC(obs2[10]), .PA_ADD(obs2[9]),
    .PR_InvertIn(obs2[8]), .PR_Write_A(obs2[7]),
    .PF_Write_S(obs2[6]), .PF_Write_Z(obs2[5]), .PF_Write_H(obs2[4]), .PF_Write_PV(obs2[3]),
    .PF_Write_N(obs2[2]), .PF_Write_C(obs2[1]), .P2_Set_CM1(obs2[0])
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobe vector for one phase of an instruction.
  function automatic logic [34:0] exp_vec(input logic [2:0] ph, input logic [1:0] ad, input logic [7:0] op);
    logic [34:0] v;
    int sss, ooo;
    v   = '0;
    sss = int'(op[2:0]);
    ooo = int'(op[5:3]);
    if (ph == PH_IDLE) return v;
    v[34] = 1'b1;
    case (ph)
      PH_RA0, PH_RA1, PH_RA2: begin
        v[32 - int'(ad)] = 1'b1;
        v[28 - int'(ph)] = 1'b1;
      end
      PH_EXEC: begin
        v[18 + sss] = 1'b1;
        v[17]       = 1'b1;
        v[9 + ooo]  = 1'b1;
        v[8]        = (ooo == 2) || (ooo == 3) || (ooo == 7);
        v[7]        = (ooo != 7);
        v[6:1]      = '1;
      end
      PH_DONE: v[0] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] ad;
    logic       dsp;
  } rec_t;

  rec_t       plan[$];
  logic [7:0] disp_exp;

  // Appends one read of w wait cycles; returns 1 if it ends in a timeout.
  function automatic bit add_read(input logic [1:0] ad, input int w, input logic dsp);
    plan.push_back(rec_t'{PH_RA0, ad, dsp});
    for (int i = 0; i < w && i < WLIM; i++) plan.push_back(rec_t'{PH_RA1, ad, dsp});
    if (w >= WLIM) return 1'b1;
    plan.push_back(rec_t'{PH_RA2, ad, dsp});
    return 1'b0;
  endfunction

  task automatic chk_noimm(input logic [7:0] op);
    logic [34:0] e;
    logic        legal2;
    legal2 = (op[7:6] == 2'b10);
    if (!legal2)                 e = 35'd1 << 33;
    else if (op[2:0] == 3'b110)  e = exp_vec(PH_RA0, AD_HL, op);
    else                         e = exp_vec(PH_EXEC, AD_PC, op);
    chk("noimm_vec", obs2, e);
    chk("noimm_xpt", xpt2, legal2 ? 1 : 0);
    chk("noimm_disp", disp2, 0);
  endtask

  // Starts at posedge+1 with the DUT idle; ends at posedge+1 with it idle again.
  task automatic run_instr(input logic [7:0] op, input logic [1:0] pfx, input int w0, input int w1,
                           input int abort_at, input int dval);
    bit         legal, to, err_end;
    rec_t       r;
    logic [7:0] nxt_disp;
    logic [1:0] eff;
    legal = (op[7:6] == 2'b10) || ((op[7:6] == 2'b11) && (op[2:0] == 3'b110));
    eff   = (pfx == 2'b11) ? 2'b00 : pfx;
    plan.delete();
    to = 1'b0;
    if (legal) begin
      if (op[2:0] != 3'b110)     to = 1'b0;
      else if (op[7:6] == 2'b11) to = add_read(AD_PC, w0, 1'b0);
      else if (eff == 2'b00)     to = add_read(AD_HL, w0, 1'b0);
      else begin
        to = add_read(AD_PC, w0, 1'b1);
        if (!to) to = add_read((eff == 2'b01) ? AD_IX : AD_IY, w1, 1'b0);
      end
      if (!to) begin
        plan.push_back(rec_t'{PH_EXEC, AD_PC, 1'b0});
        plan.push_back(rec_t'{PH_DONE, AD_PC, 1'b0});
      end
    end
    err_end = !legal || (to && (abort_at < 0 || abort_at >= plan.size()));

    Start = 1'b1; Opcode = op; Prefix = pfx; Abort = 1'b0;
    MemReady = 1'($urandom); MemData = 8'($urandom);
    @(negedge CLK);
    chk("start_vec", obs, 0);
    chk("start_xpt", xpt, 0);
    @(posedge CLK); #1;

    for (int k = 0; k < plan.size(); k++) begin
      r        = plan[k];
      Start    = 1'($urandom);
      Opcode   = 8'($urandom);
      Prefix   = 2'($urandom);
      MemReady = (r.ph == PH_RA2) ? 1'b1 : (r.ph == PH_RA1) ? 1'b0 : 1'($urandom);
      MemData  = (dval >= 0) ? 8'(dval) : 8'($urandom);
      Abort    = (k == abort_at);
      nxt_disp = disp_exp;
      if (r.ph == PH_RA2 && r.dsp && k != abort_at) nxt_disp = MemData;
      @(negedge CLK);
      chk("rec_vec", obs, exp_vec(r.ph, r.ad, op));
      chk("rec_xpt", xpt, (k + 1 > XMAX) ? XMAX : k + 1);
      chk("rec_disp", disp, disp_exp);
      if (k == 0) chk_noimm(op);
      disp_exp = nxt_disp;
      @(posedge CLK); #1;
      if (k == abort_at) break;
    end

    Start = 1'b0; Abort = 1'b0; MemReady = 1'($urandom);
    @(negedge CLK);
    if (plan.size() == 0) chk_noimm(op);
    chk("end_vec", obs, err_end ? (35'd1 << 33) : 35'd0);
    chk("end_xpt", xpt, 0);
    chk("end_disp", disp, disp_exp);
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         sel, w0, w1, ab;
    logic [7:0] op;
    logic [1:0] pfx;
    RESET = 1'b1; Start = 1'b0; Opcode = '0; Prefix = '0; Abort = 1'b0;
    MemReady = 1'b0; MemData = '0; disp_exp = '0;
    #3;
    chk("rst_vec", obs, 0);
    chk("rst_xpt", xpt, 0);
    chk("rst_disp", disp, 0);
    chk("rst_vec2", obs2, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;

    run_instr(8'h80, 2'b00, 0, 0, -1, -1);   // ADD A,B
    run_instr(8'hBE, 2'b00, 2, 0, -1, -1);   // CP (HL), two wait cycles
    run_instr(8'h96, 2'b01, 0, 0, -1, 8'hFE); // SUB (IX+d), d = 0xFE
    run_instr(8'hC6, 2'b00, 0, 0, -1, -1);   // ADD A,n; illegal on the no-imm instance
    run_instr(8'h00, 2'b00, 0, 0, -1, -1);   // illegal on both
    run_instr(8'h86, 2'b00, 3, 0, -1, -1);   // ADD (HL), wait timeout
    run_instr(8'h86, 2'b00, 3, 0, 1, -1);    // same, aborted in first RA1
    run_instr(8'hA6, 2'b10, 1, 2, -1, -1);   // AND (IY+d) with waits, XPT saturates

    // Asynchronous reset during an EXEC cycle.
    Start = 1'b1; Opcode = 8'h90; Prefix = 2'b00;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(negedge CLK);
    chk("rst_pre_exec", obs, exp_vec(PH_EXEC, AD_PC, 8'h90));
    #2 RESET = 1'b1;
    #1;
    chk("rst_async_vec", obs, 0);
    chk("rst_async_xpt", xpt, 0);
    chk("rst_async_disp", disp, 0);
    disp_exp = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    run_instr(8'hA8, 2'b00, 0, 0, -1, -1);   // XOR B after reset

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      op  = 8'($urandom);
      if (sel < 5) begin
        op[7:6] = 2'b10;
        if ($urandom_range(0, 1) == 1) op[2:0] = 3'b110;
      end else if (sel < 8) begin
        op = {2'b11, op[5:3], 3'b110};
      end
      pfx = 2'($urandom);
      w0  = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 4) : $urandom_range(0, 2);
      w1  = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 4) : $urandom_range(0, 2);
      ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : -1;
      run_instr(op, pfx, w0, w1, ab, -1);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_group_sequencer.md
Name: alu_group_sequencer

Overview:
- Clocked successor to the combinational 8-bit ALU-group opcode decoder (10 ooo sss forms).
- Sequences the whole ALU instruction class on its own step counter:
  - register operand;
  - (HL) operand;
  - immediate operand (11 ooo 110);
  - indexed (IX+d)/(IY+d) operand.
- Emits the same strobe families (PI_/PC_/PA_/PR_/PF_/P2_) plus a busy/error handshake.
- Sits between the opcode fetch stage and the ALU/register-file datapath.

Parameters:
XPT_WIDTH, 5, width of the exported step counter XPT; saturates at 2^XPT_WIDTH-1
ENABLE_IMM, 1, 1 = accept 11 ooo 110 immediate forms; 0 = treat them as illegal
ENABLE_INDEX, 1, 1 = honour Prefix for indexed memory operand; 0 = ignore Prefix (plain (HL))
WAIT_LIMIT, 0, max MemReady-low cycles per read before error; 0 = unlimited

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
Start  in  1  opcode valid; sampled only in IDLE
Opcode  in  8  opcode byte, sampled with Start
Prefix  in  2  00 none, 01 IX, 10 IY, 11 reserved (treated as none)
Abort  in  1  synchronous abort, returns to IDLE
MemReady  in  1  read-data-valid handshake from the memory interface
MemData  in  8  read data; captured only in the displacement read
Busy  out  1  high in every state except IDLE
Error  out  1  one-cycle pulse on illegal opcode or wait timeout
XPT  out  XPT_WIDTH  cycles since Start accepted
Disp  out  8  latched index displacement, raw and not sign-extended
PI_SelectAd_PC, PI_SelectAd_HL, PI_SelectAd_IX, PI_SelectAd_IY  out  1 each  address source, held for a whole read
PC_RA0, PC_RA1, PC_RA2  out  1 each  read phases: address, wait, capture
PA_Select_B_low, PA_Select_C_low, PA_Select_D_low, PA_Select_E_low, PA_Select_H_low, PA_Select_L_low, PA_Select_A_low, PA_Select_Mem_low  out  1 each  low operand source (one-hot in EXEC)
PA_Select_A_high  out  1  high operand = A (EXEC)
PA_ADD, PA_ADC, PA_SUB, PA_SBC, PA_AND, PA_XOR, PA_OR, PA_CP  out  1 each  ALU op (one-hot in EXEC)
PR_InvertIn  out  1  EXEC, for SUB/SBC/CP
PR_Write_A  out  1  EXEC, all ops except CP
PF_Write_S, PF_Write_Z, PF_Write_H, PF_Write_PV, PF_Write_N, PF_Write_C  out  1 each  flag write enables (EXEC)
P2_Set_CM1  out  1  DONE pulse: start the next M1

Behaviour:
- RESET: state IDLE, XPT=0, Disp=0, latched opcode=0, every output 0. Asserting RESET mid-instruction aborts immediately; no strobe may glitch high.
- All outputs are decoded from registered state and the latched opcode; none are combinational from inputs, except PC_RA1/PC_RA2, which follow MemReady inside a read.
- IDLE, Start=1:
  - Legal forms: Opcode[7:6]=10, or Opcode=11ooo110 with ENABLE_IMM=1.
  - Illegal: Error pulses the next cycle; state stays IDLE.
  - Legal: latch Opcode (and Prefix when ENABLE_INDEX=1) and select the next state:
    - sss!=110 -> EXEC;
    - 10ooo110 with latched prefix none -> MEM (addr HL);
    - 10ooo110 with IX/IY -> DISP;
    - 11ooo110 -> MEM (addr PC).
- Read sequence (DISP and MEM alike):
  - Cycle 1 asserts PC_RA0 and ignores MemReady.
  - Each later cycle asserts PC_RA2 if MemReady=1 (capture, leave the state), else PC_RA1.
  - The PI_SelectAd_* strobe is held for the whole read.
- DISP uses PC as address. On capture, Disp<=MemData, then go to MEM with address IX or IY per the latched prefix.
- MEM capture -> EXEC. The operand itself is latched by the datapath on PC_RA2; this block only sequences.
- Wait timeout:
  - A wait counter restarts at each read.
  - If WAIT_LIMIT!=0 and WAIT_LIMIT consecutive RA1 cycles have elapsed with MemReady still low, pulse Error and go to IDLE.
- EXEC (1 cycle):
  - ALU op one-hot from ooo: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 XOR, 110 OR, 111 CP.
  - Operand: sss 000..111 -> B, C, D, E, H, L, Mem, A. Immediate and indexed forms also use Mem.
  - Always asserted: PA_Select_A_high and all six PF_Write_*.
  - PR_InvertIn for ooo in {010, 011, 111}; PR_Write_A for ooo != 111.
  - Then go to DONE.
- DONE (1 cycle): P2_Set_CM1=1, then IDLE. Start is ignored in DONE because Busy=1.
- XPT:
  - 0 in IDLE.
  - Increments every cycle while Busy, saturating at 2^XPT_WIDTH-1.
  - Returns to 0 on entering IDLE.
- Abort=1 in any non-IDLE state forces IDLE next cycle with no EXEC/DONE strobes and no Error. Abort beats a simultaneous MemReady capture or timeout.
- Latency from the Start cycle to DONE, with zero-wait memory: register 2, (HL)/immediate 4, indexed 6 cycles. Each extra wait cycle adds 1 per read.

Test Plan:
- Opcode 0x80 (ADD A,B), Start for 1 cycle -> next cycle EXEC with PA_ADD, PA_Select_B_low, PR_Write_A and all PF_Write_*; cycle after that P2_Set_CM1; XPT 1 then 2; Busy low on cycle 3.
- Opcode 0xBE (CP (HL)), MemReady low for 2 RA cycles then high -> RA0, RA1, RA1, RA2 with PI_SelectAd_HL held throughout; EXEC asserts PA_CP, PR_InvertIn, PA_Select_Mem_low and not PR_Write_A.
- Prefix=01, Opcode 0x96, MemData=0xFE with zero wait -> Disp=0xFE, PI_SelectAd_PC read then PI_SelectAd_IX read, EXEC asserts PA_SUB; DONE 6 cycles after Start.
- ENABLE_IMM=0, Opcode 0xC6 -> Error pulse, Busy stays 0; Opcode 0x00 -> Error pulse.
- WAIT_LIMIT=3, Opcode 0x86 with MemReady held 0 -> Error after 3 RA1 cycles, back to IDLE with XPT=0; repeat with Abort raised in the first RA1 cycle -> IDLE without Error.
- RESET asserted asynchronously during an EXEC cycle -> all strobes 0 immediately; after release, a Start of 0xA8 completes normally with PA_XOR.
